// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath: default layer dimensions,
// the operand pair carried to the controller and the streamer FSM states.
package conv_pkg;

  localparam int DEFAULT_DATA_WIDTH         = 16;
  localparam int DEFAULT_FEATURE_MAP_WIDTH  = 1024;
  localparam int DEFAULT_FEATURE_MAP_HEIGHT = 1024;
  localparam int DEFAULT_INPUT_NB_CHANNELS  = 64;
  localparam int DEFAULT_OUTPUT_NB_CHANNELS = 64;
  localparam int DEFAULT_KERNEL_SIZE        = 3;
  localparam int DEFAULT_ACT_ADDR_WIDTH     = 32;
  localparam int DEFAULT_WGT_ADDR_WIDTH     = 32;

  localparam int PAD = (DEFAULT_KERNEL_SIZE - 1) / 2;

  typedef struct packed {
    logic [DEFAULT_DATA_WIDTH-1:0] a;
    logic [DEFAULT_DATA_WIDTH-1:0] b;
  } operand_pair_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } streamer_state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/operand_pair_fifo.sv
// Two-entry FIFO holding operand pairs between the SRAM return path and the
// consumer. A push while full is accepted only when a pop happens in the same
// cycle.
module operand_pair_fifo
  import conv_pkg::*;
#(
  parameter type entry_t = operand_pair_t
) (
  input  logic       clk,
  input  logic       arst_n_in,
  input  logic       push_i,
  input  entry_t     data_i,
  input  logic       pop_i,
  output entry_t     head_o,
  output logic       full_o,
  output logic       empty_o,
  output logic [1:0] count_o
);

  entry_t     mem_q [2];
  logic       wrPtr_q;
  logic       rdPtr_q;
  logic [1:0] count_q;
  logic       doPush;
  logic       doPop;

  // Status flags and the accepted push/pop for this cycle.
  always_comb begin
    full_o  = (count_q == 2'd2);
    empty_o = (count_q == 2'd0);
    doPop   = pop_i && !empty_o;
    doPush  = push_i && (!full_o || doPop);
    head_o  = mem_q[rdPtr_q];
    count_o = count_q;
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wrPtr_q  <= 1'b0;
      rdPtr_q  <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (doPush) begin
        mem_q[wrPtr_q] <= data_i;
        wrPtr_q        <= ~wrPtr_q;
      end
      if (doPop) begin
        rdPtr_q <= ~rdPtr_q;
      end
      if (doPush && !doPop) begin
        count_q <= count_q + 2'd1;
      end else if (doPop && !doPush) begin
        count_q <= count_q - 2'd1;
      end
    end
  end

endmodule

// File: rtl/conv_operand_streamer.sv
// Walks the convolution loop nest (x, y, ch_in, ch_out, k_v, k_h), reads one
// activation and one weight per MAC and hands them to the controller as a
// valid/ready pair. Out-of-image taps skip the activation read and yield 0.
module conv_operand_streamer
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH         = DEFAULT_DATA_WIDTH,
  parameter int FEATURE_MAP_WIDTH  = DEFAULT_FEATURE_MAP_WIDTH,
  parameter int FEATURE_MAP_HEIGHT = DEFAULT_FEATURE_MAP_HEIGHT,
  parameter int INPUT_NB_CHANNELS  = DEFAULT_INPUT_NB_CHANNELS,
  parameter int OUTPUT_NB_CHANNELS = DEFAULT_OUTPUT_NB_CHANNELS,
  parameter int KERNEL_SIZE        = DEFAULT_KERNEL_SIZE,
  parameter int ACT_ADDR_WIDTH     = DEFAULT_ACT_ADDR_WIDTH,
  parameter int WGT_ADDR_WIDTH     = DEFAULT_WGT_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      arst_n_in,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      act_re,
  output logic [ACT_ADDR_WIDTH-1:0] act_addr,
  input  logic [DATA_WIDTH-1:0]     act_rdata,
  output logic                      wgt_re,
  output logic [WGT_ADDR_WIDTH-1:0] wgt_addr,
  input  logic [DATA_WIDTH-1:0]     wgt_rdata,
  output logic [DATA_WIDTH-1:0]     a_data,
  output logic [DATA_WIDTH-1:0]     b_data,
  output logic                      a_valid,
  output logic                      b_valid,
  input  logic                      a_ready,
  input  logic                      b_ready
);

  localparam int XW  = cnt_width(FEATURE_MAP_WIDTH);
  localparam int YW  = cnt_width(FEATURE_MAP_HEIGHT);
  localparam int CIW = cnt_width(INPUT_NB_CHANNELS);
  localparam int COW = cnt_width(OUTPUT_NB_CHANNELS);
  localparam int KW  = cnt_width(KERNEL_SIZE);

  localparam int HALF_K = (KERNEL_SIZE - 1) / 2;

  localparam logic [XW-1:0]  X_LAST  = XW'(FEATURE_MAP_WIDTH - 1);
  localparam logic [YW-1:0]  Y_LAST  = YW'(FEATURE_MAP_HEIGHT - 1);
  localparam logic [CIW-1:0] CI_LAST = CIW'(INPUT_NB_CHANNELS - 1);
  localparam logic [COW-1:0] CO_LAST = COW'(OUTPUT_NB_CHANNELS - 1);
  localparam logic [KW-1:0]  K_LAST  = KW'(KERNEL_SIZE - 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
  } pair_t;

  streamer_state_t state_q, state_d;
  logic [XW-1:0]   xCnt_q, xCnt_d;
  logic [YW-1:0]   yCnt_q, yCnt_d;
  logic [CIW-1:0]  ciCnt_q, ciCnt_d;
  logic [COW-1:0]  coCnt_q, coCnt_d;
  logic [KW-1:0]   kvCnt_q, kvCnt_d;
  logic [KW-1:0]   khCnt_q, khCnt_d;
  logic            inflight_q;
  logic            padFlag_q;
  logic            done_q, done_d;

  int              ix, iy;
  int              actAddrInt, wgtAddrInt;
  logic            tapPad;
  logic            cKh, cKv, cCo, cCi, cY, lastPair;
  logic            issue;
  logic            clearCnt;
  logic [2:0]      pending;
  logic            transfer;
  logic            outValid;
  pair_t           incoming, fifoHead, outPair;
  logic            fifoPush, fifoPop, fifoFull, fifoEmpty;
  logic [1:0]      fifoCount;

  // Tap position, padding decision and both SRAM addresses for the current pair.
  always_comb begin
    ix         = int'(xCnt_q) + int'(khCnt_q) - HALF_K;
    iy         = int'(yCnt_q) + int'(kvCnt_q) - HALF_K;
    tapPad     = (ix < 0) || (ix >= FEATURE_MAP_WIDTH) ||
                 (iy < 0) || (iy >= FEATURE_MAP_HEIGHT);
    actAddrInt = (iy * FEATURE_MAP_WIDTH + ix) * INPUT_NB_CHANNELS + int'(ciCnt_q);
    wgtAddrInt = ((int'(coCnt_q) * INPUT_NB_CHANNELS + int'(ciCnt_q)) * KERNEL_SIZE
                  + int'(kvCnt_q)) * KERNEL_SIZE + int'(khCnt_q);
  end

  // Carry chain of the loop nest and the read-issue credit check.
  always_comb begin
    cKh      = (khCnt_q == K_LAST);
    cKv      = cKh && (kvCnt_q == K_LAST);
    cCo      = cKv && (coCnt_q == CO_LAST);
    cCi      = cCo && (ciCnt_q == CI_LAST);
    cY       = cCi && (yCnt_q == Y_LAST);
    lastPair = cY && (xCnt_q == X_LAST);
    pending  = {1'b0, fifoCount} + {2'b00, inflight_q};
    issue    = (state_q == ISSUE) && !fifoFull && (pending < 3'd2);
    act_re   = issue && !tapPad;
    wgt_re   = issue;
    act_addr = act_re ? ACT_ADDR_WIDTH'(actAddrInt) : '0;
    wgt_addr = issue ? WGT_ADDR_WIDTH'(wgtAddrInt) : '0;
  end

  // Output side: returning SRAM data bypasses an empty FIFO, otherwise the head is shown.
  always_comb begin
    incoming.a = padFlag_q ? '0 : act_rdata;
    incoming.b = wgt_rdata;
    outValid   = !fifoEmpty || inflight_q;
    outPair    = fifoEmpty ? incoming : fifoHead;
    transfer   = outValid && a_ready && b_ready;
    fifoPush   = inflight_q && !(fifoEmpty && transfer);
    fifoPop    = transfer && !fifoEmpty;
    a_valid    = outValid;
    b_valid    = outValid;
    a_data     = outValid ? outPair.a : '0;
    b_data     = outValid ? outPair.b : '0;
    busy       = (state_q != IDLE);
    done       = done_q;
  end

  // Layer sequencing: start, issue all pairs, then wait for the last transfer.
  always_comb begin
    state_d  = state_q;
    clearCnt = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = ISSUE;
          clearCnt = 1'b1;
        end
      end
      ISSUE: begin
        if (issue && lastPair) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (transfer && (pending == 3'd1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Loop counters advance once per issued pair, innermost first.
  always_comb begin
    xCnt_d  = xCnt_q;
    yCnt_d  = yCnt_q;
    ciCnt_d = ciCnt_q;
    coCnt_d = coCnt_q;
    kvCnt_d = kvCnt_q;
    khCnt_d = khCnt_q;
    if (clearCnt) begin
      xCnt_d  = '0;
      yCnt_d  = '0;
      ciCnt_d = '0;
      coCnt_d = '0;
      kvCnt_d = '0;
      khCnt_d = '0;
    end else if (issue) begin
      khCnt_d = cKh ? '0 : khCnt_q + KW'(1);
      if (cKh) kvCnt_d = (kvCnt_q == K_LAST) ? '0 : kvCnt_q + KW'(1);
      if (cKv) coCnt_d = (coCnt_q == CO_LAST) ? '0 : coCnt_q + COW'(1);
      if (cCo) ciCnt_d = (ciCnt_q == CI_LAST) ? '0 : ciCnt_q + CIW'(1);
      if (cCi) yCnt_d = (yCnt_q == Y_LAST) ? '0 : yCnt_q + YW'(1);
      if (cY)  xCnt_d = (xCnt_q == X_LAST) ? '0 : xCnt_q + XW'(1);
    end
  end

  // State, counters and the one-deep in-flight read tracker with its padding flag.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q    <= IDLE;
      xCnt_q     <= '0;
      yCnt_q     <= '0;
      ciCnt_q    <= '0;
      coCnt_q    <= '0;
      kvCnt_q    <= '0;
      khCnt_q    <= '0;
      inflight_q <= 1'b0;
      padFlag_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      xCnt_q     <= xCnt_d;
      yCnt_q     <= yCnt_d;
      ciCnt_q    <= ciCnt_d;
      coCnt_q    <= coCnt_d;
      kvCnt_q    <= kvCnt_d;
      khCnt_q    <= khCnt_d;
      inflight_q <= issue;
      padFlag_q  <= issue && tapPad;
      done_q     <= done_d;
    end
  end

  operand_pair_fifo #(
    .entry_t(pair_t)
  ) pairFifo (
    .clk      (clk),
    .arst_n_in(arst_n_in),
    .push_i   (fifoPush),
    .data_i   (incoming),
    .pop_i    (fifoPop),
    .head_o   (fifoHead),
    .full_o   (fifoFull),
    .empty_o  (fifoEmpty),
    .count_o  (fifoCount)
  );

endmodule

// File: tb/tb_conv_operand_streamer.sv
// Bench for conv_operand_streamer on a 4x4x2x2 layer with a 3x3 kernel.
// SRAMs return mem[i] = i+1 one cycle after a read; the expected pair stream
// comes from a direct walk of the loop nest.
module tb_conv_operand_streamer;

  localparam int W = 4;
  localparam int H = 4;
  localparam int CIN = 2;
  localparam int COUT = 2;
  localparam int K = 3;
  localparam int DW = 16;
  localparam int NPAIRS = W * H * CIN * COUT * K * K;

  logic          clk = 1'b0;
  logic          arst_n_in;
  logic          start;
  logic          busy, done;
  logic          act_re, wgt_re;
  logic [31:0]   act_addr, wgt_addr;
  logic [DW-1:0] act_rdata, wgt_rdata;
  logic [DW-1:0] a_data, b_data;
  logic          a_valid, b_valid;
  logic          a_ready, b_ready;

  int checksTotal = 0;
  int checksPassed = 0;

  int expA [NPAIRS];
  int expB [NPAIRS];
  int expActAddr [NPAIRS];
  int expWgtAddr [NPAIRS];
  bit expPad [NPAIRS];

  int cyc = 0;
  int runCyc = 0;
  int issueIdx = 0;
  int xferIdx = 0;
  int doneCount = 0;
  int lastXferCycle = -10;
  bit holdValid = 1'b0;
  logic [DW-1:0] holdA, holdB;

  conv_operand_streamer #(
    .DATA_WIDTH(DW),
    .FEATURE_MAP_WIDTH(W),
    .FEATURE_MAP_HEIGHT(H),
    .INPUT_NB_CHANNELS(CIN),
    .OUTPUT_NB_CHANNELS(COUT),
    .KERNEL_SIZE(K),
    .ACT_ADDR_WIDTH(32),
    .WGT_ADDR_WIDTH(32)
  ) dut (
    .clk(clk),
    .arst_n_in(arst_n_in),
    .start(start),
    .busy(busy),
    .done(done),
    .act_re(act_re),
    .act_addr(act_addr),
    .act_rdata(act_rdata),
    .wgt_re(wgt_re),
    .wgt_addr(wgt_addr),
    .wgt_rdata(wgt_rdata),
    .a_data(a_data),
    .b_data(b_data),
    .a_valid(a_valid),
    .b_valid(b_valid),
    .a_ready(a_ready),
    .b_ready(b_ready)
  );

  always #5 clk = ~clk;

  // SRAM models: addressed word plus one, garbage when not read.
  always @(posedge clk) begin
    act_rdata <= act_re ? 16'(act_addr + 32'd1) : 16'($urandom);
    wgt_rdata <= wgt_re ? 16'(wgt_addr + 32'd1) : 16'($urandom);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checksTotal++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, observed, expected, cyc);
    end else begin
      checksPassed++;
    end
  endtask

  function automatic void buildModel();
    int idx;
    int ix;
    int iy;
    idx = 0;
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++)
        for (int ci = 0; ci < CIN; ci++)
          for (int co = 0; co < COUT; co++)
            for (int kv = 0; kv < K; kv++)
              for (int kh = 0; kh < K; kh++) begin
                ix = x + kh - (K - 1) / 2;
                iy = y + kv - (K - 1) / 2;
                expPad[idx] = (ix < 0) || (ix > W - 1) || (iy < 0) || (iy > H - 1);
                expActAddr[idx] = (iy * W + ix) * CIN + ci;
                expWgtAddr[idx] = ((co * CIN + ci) * K + kv) * K + kh;
                expA[idx] = expPad[idx] ? 0 : expActAddr[idx] + 1;
                expB[idx] = expWgtAddr[idx] + 1;
                idx++;
              end
  endfunction

  function automatic logic [31:0] allOut();
    return 32'({busy, done, act_re, wgt_re, a_valid, b_valid,
                |act_addr, |wgt_addr, |a_data, |b_data});
  endfunction

  // Inputs for the upcoming clock edge; a start mid-layer must be ignored.
  task automatic applyStimulus(input int mode);
    start = (runCyc == 50);
    case (mode)
      0: begin
        a_ready = 1'b1;
        b_ready = 1'b1;
      end
      1: begin
        a_ready = (cyc % 2 == 0);
        b_ready = a_ready && ($urandom_range(0, 3) != 0);
      end
      default: begin
        a_ready = ($urandom_range(0, 1) == 1);
        b_ready = ($urandom_range(0, 3) != 0);
      end
    endcase
  endtask

  task automatic sampleCycle(input int mode);
    @(negedge clk);
    cyc++;
    runCyc++;
    if (runCyc == 1) begin
      checkOutput("lat_busy_c1", 32'(busy), 32'd1);
      checkOutput("lat_valid_c1", 32'(a_valid), 32'd0);
    end
    if (runCyc == 2) checkOutput("lat_valid_c2", 32'(a_valid), 32'd1);
    if (holdValid) begin
      checkOutput("hold_valid", 32'(a_valid), 32'd1);
      checkOutput("hold_a", 32'(a_data), 32'(holdA));
      checkOutput("hold_b", 32'(b_data), 32'(holdB));
    end
    checkOutput("valid_pair", 32'(b_valid), 32'(a_valid));
    checkOutput("re_pair", 32'(act_re && !wgt_re), 32'd0);
    if (wgt_re) begin
      if (issueIdx < NPAIRS) begin
        checkOutput("rd_wgt_addr", wgt_addr, 32'(expWgtAddr[issueIdx]));
        checkOutput("rd_act_re", 32'(act_re), 32'(!expPad[issueIdx]));
        if (!expPad[issueIdx]) checkOutput("rd_act_addr", act_addr, 32'(expActAddr[issueIdx]));
      end else begin
        checkOutput("rd_overrun", 32'(issueIdx), 32'(NPAIRS - 1));
      end
      issueIdx++;
    end
    checkOutput("credit_bound", 32'(issueIdx - xferIdx <= 2), 32'd1);
    if (done) begin
      doneCount++;
      checkOutput("done_after_last", 32'(cyc - lastXferCycle), 32'd1);
      checkOutput("done_pairs", 32'(xferIdx), 32'(NPAIRS));
      checkOutput("done_busy", 32'(busy), 32'd0);
    end
    applyStimulus(mode);
    if (a_valid && a_ready && b_ready) begin
      if (xferIdx < NPAIRS) begin
        checkOutput("xfer_a", 32'(a_data), 32'(expA[xferIdx]));
        checkOutput("xfer_b", 32'(b_data), 32'(expB[xferIdx]));
      end else begin
        checkOutput("xfer_extra", 32'(xferIdx), 32'(NPAIRS - 1));
      end
      xferIdx++;
      lastXferCycle = cyc;
      holdValid = 1'b0;
    end else begin
      holdValid = a_valid;
      holdA = a_data;
      holdB = b_data;
    end
  endtask

  // One layer started at the current negedge; optionally reset after resetAt transfers.
  task automatic runLayer(input int mode, input int resetAt);
    issueIdx = 0;
    xferIdx = 0;
    doneCount = 0;
    runCyc = 0;
    holdValid = 1'b0;
    lastXferCycle = -10;
    start = 1'b1;
    for (int i = 0; i < 20000 && doneCount == 0; i++) begin
      sampleCycle(mode);
      if (resetAt >= 0 && xferIdx >= resetAt) begin
        #2 arst_n_in = 1'b0;
        #1 checkOutput("reset_async", allOut(), 32'd0);
        start = 1'b0;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          cyc++;
          checkOutput("reset_hold", allOut(), 32'd0);
        end
        arst_n_in = 1'b1;
        return;
      end
    end
    checkOutput("run_done_once", 32'(doneCount), 32'd1);
    checkOutput("run_pairs", 32'(xferIdx), 32'(NPAIRS));
    checkOutput("run_issues", 32'(issueIdx), 32'(NPAIRS));
    if (mode == 0) checkOutput("run_cycles", 32'(runCyc), 32'(NPAIRS + 2));
  endtask

  initial begin
    buildModel();
    arst_n_in = 1'b0;
    start = 1'b0;
    a_ready = 1'b1;
    b_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cyc++;
      checkOutput("reset_idle", allOut(), 32'd0);
      start = ($urandom_range(0, 1) == 1);
    end
    start = 1'b0;
    arst_n_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cyc++;
      checkOutput("idle_after_reset", allOut(), 32'd0);
    end
    $display("[TB] full-rate layer");
    runLayer(0, -1);
    $display("[TB] controller-style backpressure, started in done cycle");
    runLayer(1, -1);
    $display("[TB] random stalls with reset at pair 100");
    runLayer(2, 100);
    $display("[TB] restart after reset");
    runLayer(0, -1);
    @(negedge clk);
    checkOutput("final_idle", 32'({busy, done}), 32'd0);
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule

// File: doc/conv_operand_streamer.md
# conv_operand_streamer

Upstream feeder for `controller_fsm`: walks the convolution loop nest in the controller's order and fetches one activation (`a`) and one kernel weight (`b`) per MAC. Out-of-image taps become zero padding. It presents each a/b pair on the controller's valid/ready interface, so the controller consumes operands in exactly the order its loop counters expect. Activation and weight SRAMs sit behind it with fixed 1-cycle read latency.

## Interface
- `DATA_WIDTH`, 16, operand width
- `FEATURE_MAP_WIDTH`, 1024, output/input map width (same-size conv)
- `FEATURE_MAP_HEIGHT`, 1024, map height
- `INPUT_NB_CHANNELS`, 64, input channels
- `OUTPUT_NB_CHANNELS`, 64, output channels
- `KERNEL_SIZE`, 3, odd kernel edge
- `ACT_ADDR_WIDTH`, 32, activation SRAM address width
- `WGT_ADDR_WIDTH`, 32, weight SRAM address width

Ports:
- `clk`  in  1  clock
- `arst_n_in`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a layer; ignored while busy
- `busy`  out  1  layer in progress
- `done`  out  1  one-cycle pulse after last pair accepted
- `act_re`  out  1  activation read enable
- `act_addr`  out  ACT_ADDR_WIDTH  activation address
- `act_rdata`  in  DATA_WIDTH  data, cycle after `act_re`
- `wgt_re`  out  1  weight read enable
- `wgt_addr`  out  WGT_ADDR_WIDTH  weight address
- `wgt_rdata`  in  DATA_WIDTH  data, cycle after `wgt_re`
- `a_data`, `b_data`  out  DATA_WIDTH  operand pair
- `a_valid`, `b_valid`  out  1  pair valid (always equal)
- `a_ready`, `b_ready`  in  1  consumer ready

## Operation
- Loop order, outer to inner: x, y, ch_in, ch_out, k_v, k_h. Total pairs N = W·H·CIN·COUT·K·K.
- Tap coordinates, signed 32-bit: ix = x + k_h − (K−1)/2, iy = y + k_v − (K−1)/2.
- Padding: if ix∉[0,W−1] or iy∉[0,H−1], `act_re`=0 for that pair and `a_data`=0.
- Activation address: (iy·W + ix)·CIN + ch_in.
- Weight address: ((ch_out·CIN + ch_in)·K + k_v)·K + k_h. `wgt_re`=1 for every pair.
- Transfer: valid ∧ `a_ready` ∧ `b_ready`. While valid and not transferred, `a_data`/`b_data` are held stable.
- FSM states:
  - IDLE: `busy`=0. `start` → ISSUE and clears all counters.
  - ISSUE: issues one read pair per cycle while credit is available. After issuing pair N−1 → DRAIN.
  - DRAIN: waits until the FIFO is empty and the final transfer is done, pulses `done` → IDLE.
- Buffering:
  - 2-entry pair FIFO on the output.
  - Issue is allowed only when FIFO occupancy + in-flight reads < 2; SRAM return data is therefore never dropped.
  - FIFO full: no issue. FIFO empty: valid=0.
  - Simultaneous push and pop at full is allowed.
- Counters wrap to 0 after the last value of their loop; the carry propagates outward, same as the controller.
- `start` while busy: ignored, no state change.

## Timing
- Reset values:
  - `busy`, `done`, `act_re`, `wgt_re`, `a_valid`, `b_valid` = 0
  - `act_addr`, `wgt_addr`, `a_data`, `b_data` = 0
  - counters, FIFO and in-flight tracking cleared
- Reset mid-operation: everything returns to reset values immediately (async); pending SRAM data is discarded.
- Latency, `start` at cycle 0:
  - cycle 1: first read issued, `busy`=1
  - cycle 2: first pair valid
- Throughput: 1 pair/cycle with ready held high. Against `controller_fsm` (FETCH/MAC), 1 pair per 2 cycles.
- `done` is high in the cycle after the transfer of pair N−1. `busy` drops in the same cycle.
- `start` is accepted in IDLE, including the cycle `done` is asserted's successor.

## Structure
- Shared package `conv_pkg`:
  - default dimension parameters
  - `localparam` PAD = (KERNEL_SIZE−1)/2
  - typedef `operand_pair_t` {a, b}
  - FSM state enum `streamer_state_t` {IDLE, ISSUE, DRAIN}
- Sub-module `operand_pair_fifo`: 2-entry, `operand_pair_t` wide, push/pop/full/empty, async reset.
- Loop counters and address generation stay in the top module.
- A padding flag travels alongside each in-flight read to select 0 for `a`.

## Test plan
Parameters for all scenarios: W=H=4, CIN=COUT=2, K=3, DATA_WIDTH=16. Memories hold `mem[i]=i+1`.
- Reset/idle: assert reset with no start → every output 0 for 20 cycles; `start` pulsed while busy has no effect.
- First pairs, ready=1, start at cycle 0:
  - pair0 (iy=−1): `a`=0, `act_re`=0, `wgt_addr`=0, `b`=1
  - pair4 (k_v=1, k_h=1, ix=iy=0): `act_addr`=0, `a`=1, `b`=5
- Right/bottom edge: x=3, y=3, k_h=2 → ix=4, padded, `a`=0. At k_v=1, k_h=1: `act_addr`=(3·4+3)·2+ch_in.
- Full run, ready=1: exactly 576 pairs match the golden model; `done` pulses once, the cycle after the last transfer.
- Backpressure: ready follows the controller's pattern (high 1 of 2 cycles), plus random stalls → no loss or duplication; data stable while stalled; SRAM never overrun.
- Reset at pair 100: outputs go to 0 at once; a restart produces the sequence from pair0 again.
